// File: rtl/csa_pkg.sv
// Shared definitions for the sequential wide adder: slice width and the
// controller's state encoding.
package csa_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/csa16.sv
// 16-bit carry-select adder: the low byte ripples, and the high byte is
// precomputed for both carry values and picked by the low byte's carry.
module csa16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);

  logic [8:0] lo;
  logic [8:0] hi0;
  logic [8:0] hi1;

  assign lo  = {1'b0, a[7:0]}  + {1'b0, b[7:0]}  + {8'd0, ci};
  assign hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
  assign hi1 = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;

  assign s  = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
  assign co = lo[8] ? hi1[8] : hi0[8];

endmodule

// File: rtl/csa_wide_seq.sv
// Sequential WORDS*16-bit adder: feeds one csa16 a slice per cycle, LSB
// first, chaining the carry through a register; result held behind valid/ready.
module csa_wide_seq
  import csa_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W*WORDS-1:0] a,
  input  logic [SLICE_W*WORDS-1:0] b,
  input  logic                     ci,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*WORDS-1:0] s,
  output logic                     co,
  output logic                     ovf,
  output logic                     busy
);

  localparam int W     = SLICE_W * WORDS;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic [W-1:0]       s_reg;
  logic               carry;
  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_s;
  logic               sl_co;
  logic               accept;

  // in_ready looks at out_ready only, never at in_valid, so a consumer
  // stall cannot form a combinational loop through a producer.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  assign sl_a = a_reg[cnt*SLICE_W +: SLICE_W];
  assign sl_b = b_reg[cnt*SLICE_W +: SLICE_W];

  csa16 u_csa16 (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry),
    .s  (sl_s),
    .co (sl_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so s/co/ovf read as zero
      // during and straight after reset rather than holding stale data.
      state <= IDLE;
      cnt   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
      carry <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values of cnt/carry regardless of statement order.
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= ci;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          s_reg[cnt*SLICE_W +: SLICE_W] <= sl_s;
          carry                         <= sl_co;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= ci;
            cnt   <= '0;
            state <= RUN;
          end else if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign s         = s_reg;
  assign co        = carry;
  // Signed overflow: both operands share a sign that the sum does not.
  assign ovf       = (a_reg[W-1] == b_reg[W-1]) && (s_reg[W-1] != a_reg[W-1]);

endmodule

// File: tb/tb_csa_wide_seq.sv
// Scoreboard bench: a 4-slice instance for directed cases and a 1-slice
// instance for randomized traffic with consumer stalls.
module tb_csa_wide_seq;

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ovf;
  } exp4_t;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } exp1_t;

  logic        clk = 1'b0;
  logic        rst_n;
  longint      cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic        in_valid4, in_ready4, ci4, out_valid4, out_ready4, co4, ovf4, busy4;
  logic [63:0] a4, b4, s4;
  logic        in_valid1, in_ready1, ci1, out_valid1, out_ready1, co1, ovf1, busy1;
  logic [15:0] a1, b1, s1;

  exp4_t  q4[$];
  longint acc4[$];
  exp1_t  q1[$];
  logic   ov4_prev = 1'b0;
  bit     rnd_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csa_wide_seq #(.WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .ci(ci4), .out_valid(out_valid4), .out_ready(out_ready4),
    .s(s4), .co(co4), .ovf(ovf4), .busy(busy4)
  );

  csa_wide_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .ci(ci1), .out_valid(out_valid1), .out_ready(out_ready1),
    .s(s1), .co(co1), .ovf(ovf1), .busy(busy1)
  );

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference: plain integer addition; overflow from operand/result signs.
  function automatic exp4_t ref4(input logic [63:0] a, input logic [63:0] b, input logic c);
    logic [64:0] sum;
    exp4_t r;
    sum   = {1'b0, a} + {1'b0, b} + 65'(c);
    r.s   = sum[63:0];
    r.co  = sum[64];
    r.ovf = (a[63] == b[63]) && (r.s[63] != a[63]);
    return r;
  endfunction

  function automatic exp1_t ref1(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] sum;
    exp1_t r;
    sum   = {1'b0, a} + {1'b0, b} + 17'(c);
    r.s   = sum[15:0];
    r.co  = sum[16];
    r.ovf = (a[15] == b[15]) && (r.s[15] != a[15]);
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic op4(input logic [63:0] a, input logic [63:0] b, input logic c);
    int k = 0;
    a4 = a; b4 = b; ci4 = c; in_valid4 = 1'b1;
    @(negedge clk);
    while (!in_ready4 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready4) bound_fail("accept4_timeout");
    else begin
      q4.push_back(ref4(a, b, c));
      acc4.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    a4 = {$urandom, $urandom};
    b4 = {$urandom, $urandom};
    ci4 = 1'($urandom);
  endtask

  task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic c);
    int k = 0;
    a1 = a; b1 = b; ci1 = c; in_valid1 = 1'b1;
    @(negedge clk);
    while (!in_ready1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready1) bound_fail("accept1_timeout");
    else q1.push_back(ref1(a, b, c));
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    a1 = 16'($urandom);
    b1 = 16'($urandom);
    ci1 = 1'($urandom);
  endtask

  task automatic drain4();
    int k = 0;
    while (q4.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("drain4", 80'(q4.size()), 80'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 4-slice instance: latency on rise, result on handshake.
  always @(negedge clk) begin : mon4
    exp4_t  e;
    longint t;
    if (rst_n) begin
      if (out_valid4 && !ov4_prev) begin
        if (acc4.size() == 0) bound_fail("latency4_no_accept");
        else begin
          t = acc4.pop_front();
          check("latency4", 80'(cyc - t), 80'd4);
        end
      end
      if (out_valid4 && out_ready4) begin
        if (q4.size() == 0) bound_fail("result4_unexpected");
        else begin
          e = q4.pop_front();
          check("result4", {13'd0, co4, ovf4, s4}, {13'd0, e.co, e.ovf, e.s});
        end
      end
    end
    ov4_prev <= out_valid4;
  end

  always @(negedge clk) begin : mon1
    exp1_t e;
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) bound_fail("result1_unexpected");
      else begin
        e = q1.pop_front();
        check("result1", {62'd0, co1, ovf1, s1}, {62'd0, e.co, e.ovf, e.s});
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_on) begin
      #1;
      out_ready1 = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] sa, sb;
    exp4_t       ex;
    int          k;

    rst_n = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0; out_ready4 = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; out_ready1 = 1'b1;
    #12;
    check("reset4_outputs", {73'd0, in_ready4, out_valid4, co4, ovf4, busy4, 2'd0},
          {73'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
    check("reset4_s", 80'(s4), 80'd0);
    check("reset1_outputs", {75'd0, in_ready1, out_valid1, co1, ovf1, busy1},
          {75'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cases 1-3 issued back to back with the consumer always ready.
    op4(64'h1, 64'h2, 1'b0);
    op4(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    op4(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    drain4();

    // Stall: result must hold with in_ready low, then a same-edge handover.
    out_ready4 = 1'b0;
    sa = 64'h1234_5678_9ABC_DEF0;
    sb = 64'h8FED_CBA9_8765_4321;
    ex = ref4(sa, sb, 1'b1);
    op4(sa, sb, 1'b1);
    k = 0;
    while (!out_valid4 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid4) bound_fail("stall_wait_valid");
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", 80'(in_ready4), 80'd0);
      check("stall_hold", {13'd0, co4, ovf4, s4}, {13'd0, ex.co, ex.ovf, ex.s});
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready4 = 1'b1;
    op4(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    drain4();

    // Reset while RUN is at cnt==2.
    op4(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("busy_before_reset", 80'(busy4), 80'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset", {12'd0, in_ready4, out_valid4, busy4, co4, s4},
          {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0});
    q4.delete();
    acc4.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    op4(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1);
    for (int i = 0; i < 20; i++)
      op4({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    drain4();

    // Randomized single-slice traffic with consumer stalls.
    rnd_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      op1(16'($urandom), 16'($urandom), 1'($urandom));
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    out_ready1 = 1'b1;
    k = 0;
    while (q1.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    check("drain1", 80'(q1.size()), 80'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
